// File: rtl/sram_access_arbiter_pkg.sv
// Shared definitions for the SRAM access arbiter: FSM encoding, logic levels,
// SRAM direction codes and the fixed requester ids.
package sram_access_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

    localparam logic SRAM_READ  = 1'b1;
    localparam logic SRAM_WRITE = 1'b0;

    // Width of a requester id; grant_id is a fixed 2-bit port.
    localparam int ID_W = 2;

    localparam logic [ID_W-1:0] REQ_UART_WR = 2'd0;
    localparam logic [ID_W-1:0] REQ_UART_RD = 2'd1;
    localparam logic [ID_W-1:0] REQ_DISP    = 2'd2;

endpackage

// File: rtl/sram_access_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after the
// position following the last grant, wrapping once around the vector.
module rr_pick
    import sram_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    input  logic               last_valid,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    int start_idx;

    // Two ordered passes: ids from start_idx upward, then the wrapped ids below it.
    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        winner    = '0;
        any_req   = LOW;
        start_idx = last_valid ? ((int'(last_grant) + 1) % NUM_REQ) : 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_req && (i >= start_idx) && req[i]) begin
                any_req = HIGH;
                winner  = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_req && (i < start_idx) && req[i]) begin
                any_req = HIGH;
                winner  = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between the UART write,
// UART read and disparity requesters. Runs the trig/done handshake with a
// timeout and returns read data plus a one-cycle ack per transaction.
module sram_access_arbiter
    import sram_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      timeout_err,
    output logic                      sram_trig,
    output logic                      sram_rw,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic [DATA_W-1:0]         sram_wdata,
    input  logic [DATA_W-1:0]         sram_rdata,
    input  logic                      sram_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic               last_valid_q, last_valid_d;
    logic [ID_W-1:0]    winner;
    logic               any_req;
    logic               tmo_hit;
    logic [NUM_REQ-1:0] ack_sel;

    logic [NUM_REQ-1:0] ack_d;
    logic [DATA_W-1:0]  rdata_d;
    logic [ID_W-1:0]    grant_d;
    logic               busy_d, err_d, trig_d, rw_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .last_valid (last_valid_q),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Counter has spent its budget in the current handshake state.
    assign tmo_hit = ((state_q == ISSUE) || (state_q == BUSY)) &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
    assign ack_sel = NUM_REQ'(1) << grant_id;

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: grant, wait for done to drop, wait for done to rise, ack.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req && (sram_done == HIGH))   state_d = ISSUE;
            ISSUE:   if (sram_done == LOW)                 state_d = BUSY;
                     else if (tmo_hit)                     state_d = RESP;
            BUSY:    if ((sram_done == HIGH) || tmo_hit)   state_d = RESP;
            RESP:                                          state_d = IDLE;
            default:                                       state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and bookkeeping.
    always_comb begin
        trig_d       = sram_trig;
        rw_d         = sram_rw;
        addr_d       = sram_addr;
        wdata_d      = sram_wdata;
        grant_d      = grant_id;
        busy_d       = busy;
        ack_d        = '0;
        rdata_d      = rdata;
        err_d        = timeout_err;
        last_grant_d = last_grant_q;
        last_valid_d = last_valid_q;
        // Counter restarts on every state entry and only runs in the handshake states.
        tmo_cnt_d    = '0;
        if ((state_d == state_q) && ((state_q == ISSUE) || (state_q == BUSY)))
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (any_req && (sram_done == HIGH)) begin
                    grant_d = winner;
                    rw_d    = req_rw[winner];
                    addr_d  = addr_arr[winner];
                    wdata_d = wdata_arr[winner];
                    busy_d  = HIGH;
                    trig_d  = HIGH;
                end
            end
            ISSUE: begin
                if (sram_done == LOW) begin
                    trig_d = LOW;
                end else if (tmo_hit) begin
                    trig_d = LOW;
                    err_d  = HIGH;
                    ack_d  = ack_sel;
                end
            end
            BUSY: begin
                if (sram_done == HIGH) begin
                    if (sram_rw == SRAM_READ) rdata_d = sram_rdata;
                    ack_d = ack_sel;
                end else if (tmo_hit) begin
                    err_d = HIGH;
                    ack_d = ack_sel;
                end
            end
            RESP: begin
                busy_d       = LOW;
                rw_d         = SRAM_READ;
                last_grant_d = grant_id;
                last_valid_d = HIGH;
            end
            default: ;
        endcase
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ack          <= '0;
            rdata        <= '0;
            grant_id     <= '0;
            busy         <= LOW;
            timeout_err  <= LOW;
            sram_trig    <= LOW;
            sram_rw      <= SRAM_READ;
            sram_addr    <= '0;
            sram_wdata   <= '0;
            tmo_cnt_q    <= '0;
            last_grant_q <= '0;
            last_valid_q <= LOW;
        end else begin
            ack          <= ack_d;
            rdata        <= rdata_d;
            grant_id     <= grant_d;
            busy         <= busy_d;
            timeout_err  <= err_d;
            sram_trig    <= trig_d;
            sram_rw      <= rw_d;
            sram_addr    <= addr_d;
            sram_wdata   <= wdata_d;
            tmo_cnt_q    <= tmo_cnt_d;
            last_grant_q <= last_grant_d;
            last_valid_q <= last_valid_d;
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: a controller model answers the
// trig/done handshake, expected grants and acks are queued at stimulus time
// and popped by the controller model and the ack monitor.
module tb_sram_access_arbiter;
    import sram_access_arbiter_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 255;

    logic                      clk_in, rst_in;
    logic [NUM_REQ-1:0]        req, req_rw;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic [ID_W-1:0]           grant_id;
    logic                      busy, timeout_err, sram_trig, sram_rw;
    logic [ADDR_W-1:0]         sram_addr;
    logic [DATA_W-1:0]         sram_wdata, sram_rdata;
    logic                      sram_done;

    logic [ADDR_W-1:0] tb_addr  [NUM_REQ];
    logic [DATA_W-1:0] tb_wdata [NUM_REQ];
    assign req_addr  = {tb_addr[2], tb_addr[1], tb_addr[0]};
    assign req_wdata = {tb_wdata[2], tb_wdata[1], tb_wdata[0]};

    sram_access_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .req(req), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
        .sram_trig(sram_trig), .sram_rw(sram_rw), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_done(sram_done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0]        id;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } issue_t;

    typedef struct {
        logic [1:0]        id;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } ack_t;

    issue_t issue_q[$];
    ack_t   ack_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] model_rdata = '0;
    logic              model_err   = 1'b0;

    // controller model knobs
    int                fall_dly   = 2;
    int                rise_dly   = 3;
    logic [DATA_W-1:0] ctl_rdata  = '0;
    bit                force_busy = 1'b0;
    bit                hang       = 1'b0;
    int                mstate     = 0;
    int                mcnt       = 0;

    // monitor statistics
    int   trig_rises       = 0;
    int   trig_high_cycles = 0;
    logic prev_trig        = 1'b0;
    logic [NUM_REQ-1:0] prev_ack = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_fields(input logic [1:0] id, input logic rw,
                              input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        req_rw[id]   = rw;
        tb_addr[id]  = addr;
        tb_wdata[id] = wd;
    endtask

    task automatic expect_txn(input logic [1:0] id, input logic rw, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                              input logic tmo, input logic acked);
        issue_t is;
        ack_t   ak;
        is.id = id; is.rw = rw; is.addr = addr; is.wdata = wd;
        issue_q.push_back(is);
        if (acked) begin
            if (tmo) model_err = 1'b1;
            else if (rw == SRAM_READ) model_rdata = rd;
            ak.id = id; ak.rdata = model_rdata; ak.err = model_err;
            ack_q.push_back(ak);
        end
    endtask

    task automatic wait_ack(input logic [1:0] id, input string name);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!ack[id] && n < 400);
        check(name, ack[id], 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"},         ack,         '0);
        check({tag, "_rdata"},       rdata,       '0);
        check({tag, "_grant_id"},    grant_id,    '0);
        check({tag, "_busy"},        busy,        1'b0);
        check({tag, "_timeout_err"}, timeout_err, 1'b0);
        check({tag, "_sram_trig"},   sram_trig,   1'b0);
        check({tag, "_sram_rw"},     sram_rw,     1'b1);
        check({tag, "_sram_addr"},   sram_addr,   '0);
        check({tag, "_sram_wdata"},  sram_wdata,  '0);
    endtask

    // SRAM controller model: on trig, drop done after fall_dly cycles, raise it
    // rise_dly cycles later with ctl_rdata; the granted attributes are checked here.
    initial begin
        issue_t e;
        sram_done  = 1'b1;
        sram_rdata = '0;
        forever begin
            @(posedge clk_in);
            #1;
            if (!rst_in) begin
                mstate    = 0;
                sram_done = 1'b1;
            end else begin
                case (mstate)
                    0: begin
                        if (force_busy) begin
                            sram_done = 1'b0;
                        end else begin
                            sram_done = 1'b1;
                            if (sram_trig) begin
                                if (issue_q.size() == 0) begin
                                    check("issue_unexpected", sram_trig, 1'b0);
                                end else begin
                                    e = issue_q.pop_front();
                                    check("issue_grant_id", grant_id,   e.id);
                                    check("issue_rw",       sram_rw,    e.rw);
                                    check("issue_addr",     sram_addr,  e.addr);
                                    check("issue_wdata",    sram_wdata, e.wdata);
                                    check("issue_busy",     busy,       1'b1);
                                end
                                if (hang) begin
                                    mstate = 3;
                                end else begin
                                    mcnt   = fall_dly;
                                    mstate = 1;
                                end
                            end
                        end
                    end
                    1: begin
                        mcnt--;
                        if (mcnt <= 0) begin
                            sram_done = 1'b0;
                            mcnt      = rise_dly;
                            mstate    = 2;
                        end
                    end
                    2: begin
                        mcnt--;
                        if (mcnt <= 0) begin
                            sram_rdata = ctl_rdata;
                            sram_done  = 1'b1;
                            mstate     = 0;
                        end
                    end
                    default: if (!sram_trig) mstate = 0;
                endcase
            end
        end
    end

    // Ack monitor: pops the expected response whenever an ack appears.
    initial begin
        ack_t e;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                if (sram_trig && !prev_trig) trig_rises++;
                if (sram_trig) trig_high_cycles++;
                if (ack != '0) begin
                    check("ack_onehot",    $onehot(ack), 1'b1);
                    check("ack_one_cycle", prev_ack,     '0);
                    check("ack_busy",      busy,         1'b1);
                    if (ack_q.size() == 0) begin
                        check("ack_unexpected", ack, '0);
                    end else begin
                        e = ack_q.pop_front();
                        check("ack_id",      ack,         3'b001 << e.id);
                        check("ack_rdata",   rdata,       e.rdata);
                        check("ack_tmo_err", timeout_err, e.err);
                    end
                end
            end
            prev_ack  = ack;
            prev_trig = sram_trig;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n;
        int   rises0;
        logic bad;

        rst_in = 1'b0;
        req    = '0;
        req_rw = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tb_addr[i]  = '0;
            tb_wdata[i] = '0;
        end

        // reset state
        repeat (2) @(negedge clk_in);
        check_reset_values("reset");
        rst_in = 1'b1;
        @(negedge clk_in);

        // single write
        fall_dly = 2; rise_dly = 3;
        rises0 = trig_rises;
        set_fields(REQ_UART_WR, SRAM_WRITE, 18'h00010, 8'hA5);
        expect_txn(REQ_UART_WR, SRAM_WRITE, 18'h00010, 8'hA5, 8'h00, 1'b0, 1'b1);
        req[REQ_UART_WR] = 1'b1;
        wait_ack(REQ_UART_WR, "wr_ack_seen");
        req[REQ_UART_WR] = 1'b0;
        @(negedge clk_in);
        check("wr_busy_after",   busy,                1'b0);
        check("wr_rw_restored",  sram_rw,             SRAM_READ);
        check("wr_trig_pulses",  trig_rises - rises0, 1);
        check("wr_ack_cleared",  ack,                 '0);

        // single read, then rdata held through a write
        ctl_rdata = 8'h5C;
        set_fields(REQ_UART_RD, SRAM_READ, 18'h3FFFF, 8'h00);
        expect_txn(REQ_UART_RD, SRAM_READ, 18'h3FFFF, 8'h00, 8'h5C, 1'b0, 1'b1);
        req[REQ_UART_RD] = 1'b1;
        wait_ack(REQ_UART_RD, "rd_ack_seen");
        req[REQ_UART_RD] = 1'b0;
        set_fields(REQ_DISP, SRAM_WRITE, 18'h00100, 8'h33);
        expect_txn(REQ_DISP, SRAM_WRITE, 18'h00100, 8'h33, 8'h00, 1'b0, 1'b1);
        req[REQ_DISP] = 1'b1;
        wait_ack(REQ_DISP, "rd_hold_wr_ack_seen");
        req[REQ_DISP] = 1'b0;
        @(negedge clk_in);
        check("rd_rdata_held", rdata, 8'h5C);

        // contention: all three held, round-robin 0,1,2,0,1,2
        fall_dly = 1; rise_dly = 1;
        for (int i = 0; i < NUM_REQ; i++)
            set_fields(2'(i), SRAM_WRITE, 18'h00A00 + 18'(i), 8'h10 + 8'(i));
        for (int k = 0; k < 6; k++)
            expect_txn(2'(k % 3), SRAM_WRITE, 18'h00A00 + 18'(k % 3), 8'h10 + 8'(k % 3),
                       8'h00, 1'b0, 1'b1);
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin
                @(negedge clk_in);
                n++;
            end while (ack == '0 && n < 400);
            check("rr_ack_seen", ack != '0, 1'b1);
        end
        req = '0;
        @(negedge clk_in);

        // controller busy in IDLE: no grant until done rises
        force_busy = 1'b1;
        repeat (2) @(negedge clk_in);
        set_fields(REQ_DISP, SRAM_WRITE, 18'h20000, 8'h3C);
        expect_txn(REQ_DISP, SRAM_WRITE, 18'h20000, 8'h3C, 8'h00, 1'b0, 1'b1);
        req[REQ_DISP] = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk_in);
            bad = bad | sram_trig | busy;
        end
        check("ctl_busy_no_grant", bad, 1'b0);
        force_busy = 1'b0;
        @(negedge clk_in);
        check("ctl_busy_trig_not_yet", sram_trig, 1'b0);
        @(negedge clk_in);
        check("ctl_busy_trig_after_rise", sram_trig, 1'b1);
        wait_ack(REQ_DISP, "ctl_busy_ack_seen");
        req[REQ_DISP] = 1'b0;

        // timeout: done never falls; rdata untouched, error sticky
        hang = 1'b1;
        ctl_rdata = 8'hEE;
        set_fields(REQ_DISP, SRAM_READ, 18'h1ABCD, 8'h00);
        expect_txn(REQ_DISP, SRAM_READ, 18'h1ABCD, 8'h00, 8'hEE, 1'b1, 1'b1);
        @(negedge clk_in);
        trig_high_cycles = 0;
        req[REQ_DISP] = 1'b1;
        wait_ack(REQ_DISP, "tmo_ack_seen");
        check("tmo_trig_dropped", sram_trig,        1'b0);
        check("tmo_trig_cycles",  trig_high_cycles, TIMEOUT);
        req[REQ_DISP] = 1'b0;
        hang = 1'b0;
        ctl_rdata = 8'h77;
        set_fields(REQ_UART_RD, SRAM_READ, 18'h00042, 8'h00);
        expect_txn(REQ_UART_RD, SRAM_READ, 18'h00042, 8'h00, 8'h77, 1'b0, 1'b1);
        req[REQ_UART_RD] = 1'b1;
        wait_ack(REQ_UART_RD, "post_tmo_ack_seen");
        req[REQ_UART_RD] = 1'b0;
        @(negedge clk_in);
        check("tmo_err_sticky", timeout_err, 1'b1);

        // reset mid-BUSY: drop transaction, search restarts at id 0
        fall_dly = 1; rise_dly = 20;
        set_fields(REQ_UART_WR, SRAM_WRITE, 18'h00555, 8'h55);
        expect_txn(REQ_UART_WR, SRAM_WRITE, 18'h00555, 8'h55, 8'h00, 1'b0, 1'b0);
        req[REQ_UART_WR] = 1'b1;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (sram_done && n < 50);
        check("rst_reached_busy", sram_done, 1'b0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        req    = '0;
        #1;
        check_reset_values("midrst");
        model_rdata = '0;
        model_err   = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        fall_dly = 1; rise_dly = 1;
        set_fields(REQ_UART_RD, SRAM_WRITE, 18'h00111, 8'h01);
        set_fields(REQ_DISP,    SRAM_WRITE, 18'h00222, 8'h02);
        expect_txn(REQ_UART_RD, SRAM_WRITE, 18'h00111, 8'h01, 8'h00, 1'b0, 1'b1);
        expect_txn(REQ_DISP,    SRAM_WRITE, 18'h00222, 8'h02, 8'h00, 1'b0, 1'b1);
        req = 3'b110;
        wait_ack(REQ_UART_RD, "post_rst_first_ack");
        req[REQ_UART_RD] = 1'b0;
        wait_ack(REQ_DISP, "post_rst_second_ack");
        req[REQ_DISP] = 1'b0;

        repeat (5) @(negedge clk_in);
        check("issue_q_drained", issue_q.size(), 0);
        check("ack_q_drained",   ack_q.size(),   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
Shares the single SRAM controller between three requesters: the UART write path (0), the UART read path (1) and the disparity engine load/write-back path (2).
- Round-robin arbitration.
- Latches the winner's address, data and direction.
- Runs the controller's trig/done handshake, returns read data and a one-cycle ack per transaction.
- Removes per-path SRAM handshake sequencing from the top-level control FSM.

Parameters:
NUM_REQ, 3, number of requesters (ids 0..NUM_REQ-1).
ADDR_W, 18, SRAM address width (bank select already folded in by requester).
DATA_W, 8, SRAM data width.
TIMEOUT, 255, max cycles waited on any sram_done edge before abort.

Ports:
clk_in  in  1  clock, all logic rising-edge.
rst_in  in  1  asynchronous active-low reset.
req  in  NUM_REQ  per-requester request, held until own ack.
req_rw  in  NUM_REQ  per-requester direction, 1=read, 0=write.
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
ack  out  NUM_REQ  one-cycle completion pulse to granted requester.
rdata  out  DATA_W  read data, valid with ack, held until next read completes.
grant_id  out  2  id of current/last granted requester.
busy  out  1  high from grant until ack inclusive.
timeout_err  out  1  sticky, set on any handshake timeout.
sram_trig  out  1  controller start strobe.
sram_rw  out  1  controller direction, 1=read, 0=write.
sram_addr  out  ADDR_W  controller address.
sram_wdata  out  DATA_W  controller write data.
sram_rdata  in  DATA_W  controller read data.
sram_done  in  1  controller ready; high=idle, low=busy.

Behaviour:
- Reset values, all outputs registered:
  - ack=0, rdata=0, grant_id=0, busy=0, timeout_err=0, sram_trig=0.
  - sram_rw=1, sram_addr=0, sram_wdata=0.
  - RR pointer=0, state=IDLE, timeout counter=0.
- Controller handshake:
  - trig only while sram_done=1.
  - Controller drops sram_done after trig, raises it on completion.
- States:
  - IDLE: if any req and sram_done=1:
    - pick winner: first set req starting at (last_grant+1) mod NUM_REQ; after reset, search starts at 0.
    - latch rw/addr/wdata to sram_*; set grant_id, busy=1, sram_trig=1; go ISSUE.
  - ISSUE: hold sram_trig=1 until sram_done=0, then sram_trig=0; go BUSY.
  - BUSY: on sram_done=1:
    - if read, capture sram_rdata into rdata.
    - go RESP.
  - RESP: ack[grant_id]=1 for exactly one cycle; busy=0; sram_rw returns to 1; update last_grant; go IDLE.
- Latency: req sampled at edge N gives sram_trig high after edge N+1. Ack is asserted one cycle after sram_done rise is sampled. Minimum gap between back-to-back grants is one IDLE cycle.
- Request attributes are latched at grant. Changes to req_addr, req_wdata or req_rw during the transaction are ignored.
- req dropped mid-transaction: the transaction completes and ack still pulses; the requester ignores it.
- Simultaneous requests: resolved only by the RR pointer. A requester re-asserting right after its own ack loses to any other pending requester.
- sram_done=0 in IDLE: no grant, requests stay pending.
- Timeout:
  - The counter clears on each state entry and counts in ISSUE and BUSY.
  - On reaching TIMEOUT: sram_trig=0, timeout_err=1 (sticky), go RESP so the requester is never hung.
  - rdata is not updated on timeout.
- Reset mid-transaction: all registers return to reset values immediately (asynchronous). The in-flight transaction is dropped without ack.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, ISSUE, BUSY, RESP);
  - LOW/HIGH;
  - SRAM_READ=1, SRAM_WRITE=0;
  - requester ids REQ_UART_WR=0, REQ_UART_RD=1, REQ_DISP=2.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector, last_grant.
  - Outputs: winner id, any_req.

Test Plan:
- Single write: req[0]=1, rw=0, addr=0x00010, wdata=0xA5; sram_done falls 2 cycles after trig, rises 3 later -> one trig pulse, sram_rw=0, sram_addr=0x00010, sram_wdata=0xA5, ack[0] one cycle, busy low after.
- Single read: req[1]=1, rw=1, addr=0x3FFFF, sram_rdata=0x5C at done rise -> rdata=0x5C with ack[1], held through a following write.
- Contention: req=3'b111 held continuously -> grant order 0,1,2,0,1,2 over six transactions, exactly one ack per transaction.
- Controller busy: sram_done held 0 for 10 cycles with req[2]=1 -> no trig, busy=0; trig appears one cycle after sram_done rises.
- Timeout: sram_done never falls after trig -> after 255 cycles sram_trig=0, timeout_err=1 sticky, ack pulse to requester, next request still served.
- Reset mid-BUSY: rst_in low for 1 cycle -> all outputs at reset values immediately, no ack, next grant starts search at id 0.
